// File: rtl/haar_stage_accum.sv
// haar_stage_accum
//   Accumulates the rectangle-sum x weight products of each Haar feature,
//   compares every feature sum to its threshold, adds the selected leaf
//   value into a stage sum, and presents the stage result with a
//   valid/ready handshake.
//
// Parameters
//   PROD_W  width of the unsigned product beat
//   LEAF_W  width of the signed leaf values
//   SUM_W   width of the signed stage sum and stage threshold
//
// Ports
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   prod_valid/prod_ready   product beat handshake
//   prod_data, prod_neg     product magnitude, 1 = subtract
//   prod_last               last rectangle of the feature
//   feat_thresh, left_val,
//   right_val, stage_last   feature parameters, sampled with the prod_last beat
//   stage_thresh            stage threshold, sampled with the stage_last beat
//   res_valid/res_ready     stage result handshake
//   res_pass, res_sum       stage decision and final stage sum
//   err_rect                sticky: a feature had more than 3 beats
//
// Build option
//   HAAR_STAGE_SAT_EN       when defined the stage-sum addition saturates,
//                           otherwise it wraps modulo 2^SUM_W.

module haar_stage_accum #(
  parameter int PROD_W = 23,
  parameter int LEAF_W = 16,
  parameter int SUM_W  = 24
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       prod_valid,
  output logic                       prod_ready,
  input  logic [PROD_W-1:0]          prod_data,
  input  logic                       prod_neg,
  input  logic                       prod_last,
  input  logic signed [PROD_W+2:0]   feat_thresh,
  input  logic signed [LEAF_W-1:0]   left_val,
  input  logic signed [LEAF_W-1:0]   right_val,
  input  logic                       stage_last,
  input  logic signed [SUM_W-1:0]    stage_thresh,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_pass,
  output logic signed [SUM_W-1:0]    res_sum,
  output logic                       err_rect
);

  localparam int ACC_W = PROD_W + 3;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0]  feat_acc_p0;
  logic [1:0]               rect_cnt_p0;
  logic signed [ACC_W-1:0]  thr_p0;
  logic signed [LEAF_W-1:0] left_p0;
  logic signed [LEAF_W-1:0] right_p0;
  logic                     slast_p0;
  logic signed [SUM_W-1:0]  sthr_p0;
  logic signed [SUM_W-1:0]  stage_sum_p1;

  logic                     beat_acc;
  logic signed [ACC_W-1:0]  prod_ext_p0;
  logic signed [ACC_W-1:0]  acc_nxt_p0;
  logic signed [LEAF_W-1:0] leaf_p1;
  logic signed [SUM_W-1:0]  sum_nxt_p1;

  // Stage sum plus sign-extended leaf; saturating or wrapping by build option.
  function automatic logic signed [SUM_W-1:0] stage_add(
    input logic signed [SUM_W-1:0]  a,
    input logic signed [LEAF_W-1:0] b
  );
    logic signed [SUM_W:0] ax;
    logic signed [SUM_W:0] bx;
    logic signed [SUM_W:0] full;
    ax   = {a[SUM_W-1], a};
    bx   = {{(SUM_W + 1 - LEAF_W){b[LEAF_W-1]}}, b};
    full = ax + bx;
`ifdef HAAR_STAGE_SAT_EN
    if (full[SUM_W] != full[SUM_W-1]) begin
      if (full[SUM_W])
        return {1'b1, {(SUM_W-1){1'b0}}};
      else
        return {1'b0, {(SUM_W-1){1'b1}}};
    end
`endif
    return full[SUM_W-1:0];
  endfunction

  // FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      state <= ACC;
    else
      state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (beat_acc && prod_last) state_nxt = EVAL;
      EVAL:    state_nxt = slast_p0 ? OUT : ACC;
      OUT:     if (res_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // FSM outputs
  always_comb begin
    prod_ready = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ACC:     prod_ready = 1'b1;
      OUT:     res_valid  = 1'b1;
      default: ;
    endcase
  end

  assign beat_acc = prod_valid && prod_ready;

  // p0: feature accumulation; products are unsigned, so zero-extend them
  always_comb begin
    prod_ext_p0 = $signed({3'b000, prod_data});
    acc_nxt_p0  = prod_neg ? (feat_acc_p0 - prod_ext_p0) : (feat_acc_p0 + prod_ext_p0);
  end

  // p1: leaf selection and stage-sum update
  always_comb begin
    leaf_p1    = (feat_acc_p0 < thr_p0) ? left_p0 : right_p0;
    sum_nxt_p1 = stage_add(stage_sum_p1, leaf_p1);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      feat_acc_p0  <= '0;
      rect_cnt_p0  <= '0;
      thr_p0       <= '0;
      left_p0      <= '0;
      right_p0     <= '0;
      slast_p0     <= 1'b0;
      sthr_p0      <= '0;
      stage_sum_p1 <= '0;
      res_sum      <= '0;
      res_pass     <= 1'b0;
      err_rect     <= 1'b0;
    end else begin
      if (beat_acc) begin
        feat_acc_p0 <= acc_nxt_p0;
        rect_cnt_p0 <= rect_cnt_p0 + 2'd1;
        // the counter wraps on a 4th beat; that beat is still accumulated
        if (rect_cnt_p0 == 2'd3 && !prod_last)
          err_rect <= 1'b1;
        if (prod_last) begin
          thr_p0   <= feat_thresh;
          left_p0  <= left_val;
          right_p0 <= right_val;
          slast_p0 <= stage_last;
          if (stage_last)
            sthr_p0 <= stage_thresh;
        end
      end

      if (state == EVAL) begin
        feat_acc_p0  <= '0;
        rect_cnt_p0  <= '0;
        stage_sum_p1 <= sum_nxt_p1;
        if (slast_p0) begin
          res_sum  <= sum_nxt_p1;
          res_pass <= (sum_nxt_p1 >= sthr_p0);
        end
      end

      // result retires: the next stage starts from zero
      if (state == OUT && res_ready)
        stage_sum_p1 <= '0;
    end
  end

endmodule

// File: tb/tb_haar_stage_accum.sv
// tb_haar_stage_accum
//   Directed-vector bench for haar_stage_accum with a result scoreboard.
//   Stimulus pushes the hand-computed stage result when it issues the
//   stage_last beat; a monitor pops and compares on every result handshake.

module tb_haar_stage_accum;

  localparam int PROD_W = 23;
  localparam int LEAF_W = 16;
  localparam int SUM_W  = 24;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n = 1'b0;
  logic                     prod_valid;
  logic                     prod_ready;
  logic [PROD_W-1:0]        prod_data;
  logic                     prod_neg;
  logic                     prod_last;
  logic signed [PROD_W+2:0] feat_thresh;
  logic signed [LEAF_W-1:0] left_val;
  logic signed [LEAF_W-1:0] right_val;
  logic                     stage_last;
  logic signed [SUM_W-1:0]  stage_thresh;
  logic                     res_valid;
  logic                     res_ready;
  logic                     res_pass;
  logic signed [SUM_W-1:0]  res_sum;
  logic                     err_rect;

  always #5 ap_clk = ~ap_clk;

  haar_stage_accum #(
    .PROD_W(PROD_W),
    .LEAF_W(LEAF_W),
    .SUM_W (SUM_W)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .prod_valid  (prod_valid),
    .prod_ready  (prod_ready),
    .prod_data   (prod_data),
    .prod_neg    (prod_neg),
    .prod_last   (prod_last),
    .feat_thresh (feat_thresh),
    .left_val    (left_val),
    .right_val   (right_val),
    .stage_last  (stage_last),
    .stage_thresh(stage_thresh),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_pass    (res_pass),
    .res_sum     (res_sum),
    .err_rect    (err_rect)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int sum;
    bit pass;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_res(input int s, input bit p);
    exp_t e;
    e.sum  = s;
    e.pass = p;
    exp_q.push_back(e);
  endtask

  // Issue one beat; called just after a rising edge, returns just after
  // the edge that accepted it.
  task automatic beat(input int data, input bit neg, input bit last,
                      input int thr, input int lv, input int rv,
                      input bit sl, input int sth);
    int t;
    prod_data    = data[PROD_W-1:0];
    prod_neg     = neg;
    prod_last    = last;
    feat_thresh  = thr[PROD_W+2:0];
    left_val     = lv[LEAF_W-1:0];
    right_val    = rv[LEAF_W-1:0];
    stage_last   = sl;
    stage_thresh = sth[SUM_W-1:0];
    prod_valid   = 1'b1;
    t = 0;
    while (!prod_ready && t < 20) begin
      @(posedge ap_clk); #1;
      t++;
    end
    if (!prod_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: prod_ready %0b, required 1", prod_ready);
    end
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    stage_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((res_valid || !prod_ready) && t < 50) begin
      @(posedge ap_clk); #1;
      t++;
    end
    if (res_valid || !prod_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: res_valid %0b prod_ready %0b, required 0/1",
               res_valid, prod_ready);
    end
  endtask

  // Scoreboard monitor
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL res_unexpected: got sum %0d, required no result", res_sum);
      end else begin
        e = exp_q.pop_front();
        chk("res_sum", res_sum, e.sum);
        chk("res_pass", res_pass, e.pass);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    prod_valid   = 1'b0;
    prod_data    = '0;
    prod_neg     = 1'b0;
    prod_last    = 1'b0;
    feat_thresh  = '0;
    left_val     = '0;
    right_val    = '0;
    stage_last   = 1'b0;
    stage_thresh = '0;
    res_ready    = 1'b1;

    // reset state
    #12;
    chk("rst_prod_ready", prod_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_pass", res_pass, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_err_rect", err_rect, 0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    // three beats, 750 < 800 -> left -5; latency check
    expect_res(-5, 1'b0);
    beat(1000, 0, 0, 0, 0, 0, 0, 0);
    beat(300, 1, 0, 0, 0, 0, 0, 0);
    beat(50, 0, 1, 800, -5, 7, 1, 0);
    chk("lat_eval_valid", res_valid, 0);
    chk("lat_eval_ready", prod_ready, 0);
    @(posedge ap_clk); #1;
    chk("lat_out_valid", res_valid, 1);
    @(posedge ap_clk); #1;
    chk("retire_ready", prod_ready, 1);

    // two features: right 20 + left 15 = 35 >= 35
    expect_res(35, 1'b1);
    beat(100, 0, 1, 50, -1, 20, 0, 0);
    beat(10, 0, 1, 50, 15, 99, 1, 35);

    // product MSB set must be zero-extended: 8388607 >= 100 -> right 1
    expect_res(1, 1'b1);
    beat(8388607, 0, 1, 100, -1, 1, 1, 1);

    // signed compare: -20 < 5 -> left 11
    expect_res(11, 1'b1);
    beat(20, 1, 1, 5, 11, -11, 1, 11);
    wait_idle();

    // result held with res_ready low while upstream keeps offering beats
    res_ready = 1'b0;
    expect_res(-4, 1'b1);
    beat(7, 0, 1, 0, 99, -4, 1, -4);
    @(posedge ap_clk); #1;
    prod_valid = 1'b1;
    prod_data  = 23'd123;
    prod_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_prod_ready", prod_ready, 0);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_sum", res_sum, -4);
      @(posedge ap_clk); #1;
    end
    res_ready = 1'b1;
    @(posedge ap_clk); #1;
    chk("release_prod_ready", prod_ready, 1);
    chk("release_res_valid", res_valid, 0);
    prod_valid = 1'b0;
    prod_last  = 1'b0;

    // four beats without prod_last -> sticky err_rect
    chk("err_before", err_rect, 0);
    beat(1, 0, 0, 0, 0, 0, 0, 0);
    beat(1, 0, 0, 0, 0, 0, 0, 0);
    beat(1, 0, 0, 0, 0, 0, 0, 0);
    chk("err_after3", err_rect, 0);
    beat(1, 0, 0, 0, 0, 0, 0, 0);
    chk("err_after4", err_rect, 1);
    expect_res(2, 1'b1);
    beat(1, 0, 1, 0, -2, 2, 1, 0);
    wait_idle();
    chk("err_sticky", err_rect, 1);

    // stage sum 2^23-10 then leaf +20
`ifdef HAAR_STAGE_SAT_EN
    expect_res(8388607, 1'b1);
`else
    expect_res(-8388598, 1'b0);
`endif
    for (int i = 0; i < 256; i++)
      beat(32767, 0, 1, 0, 0, 32767, 0, 0);
    beat(246, 0, 1, 0, 0, 246, 0, 0);
    beat(1, 0, 1, 0, 0, 20, 1, 0);
    wait_idle();

    // reset mid-feature discards stage sum, partial feature and error flag
    beat(50, 0, 1, 0, 0, 40, 0, 0);
    beat(1000, 1, 0, 0, 0, 0, 0, 0);
    beat(1000, 1, 0, 0, 0, 0, 0, 0);
    ap_rst_n = 1'b0;
    #1;
    chk("arst_prod_ready", prod_ready, 1);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_pass", res_pass, 0);
    chk("arst_res_sum", res_sum, 0);
    chk("arst_err_rect", err_rect, 0);
    #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    expect_res(3, 1'b1);
    beat(5, 0, 1, 0, -9, 3, 1, 0);
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
